ct_spsram_2048x59_arb: RTL

Arbiter and init/flush sequencer for a single-port 2048x59 SRAM macro with active-low chip enable, global write enable and per-bit write enables. It shares the one SRAM port between a read requester and a write requester, one access per cycle. After reset and on demand, it sweeps all entries to a known value. It sits directly in front of the SRAM macro, and all array traffic passes through it.

---
 rtl/ct_spsram_2048x59_arb_if.sv | 36 +++
 rtl/ct_spsram_2048x59_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ct_spsram_2048x59_arb_if.sv
// Request/response and SRAM-pin bundle for the single-port SRAM arbiter.
// slave modport: arbiter side (takes requests and sram_q, drives grants, read data and SRAM pins).
// master modport: requester/macro side (the mirror image).
interface ct_spsram_2048x59_arb_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 59
);
    logic                  rd_req_vld;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_gnt;
    logic                  rd_data_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req_vld;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [DATA_WIDTH-1:0] wr_req_data;
    logic [DATA_WIDTH-1:0] wr_req_bmask;
    logic                  wr_req_gnt;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  rd_req_vld, rd_req_addr, wr_req_vld, wr_req_addr, wr_req_data, wr_req_bmask, sram_q,
        output rd_req_gnt, rd_data_vld, rd_data, wr_req_gnt,
        output sram_a, sram_cen, sram_d, sram_gwen, sram_wen
    );

    modport master (
        output rd_req_vld, rd_req_addr, wr_req_vld, wr_req_addr, wr_req_data, wr_req_bmask, sram_q,
        input  rd_req_gnt, rd_data_vld, rd_data, wr_req_gnt,
        input  sram_a, sram_cen, sram_d, sram_gwen, sram_wen
    );
endinterface

// File: rtl/ct_spsram_2048x59_arb.sv
// Arbiter plus init/flush sweeper in front of a single-port 2048x59 SRAM macro.
// Latency: grants are combinational; read data returns one cycle after the read grant.
// Backpressure: a requester holds its request until it sees gnt; no grants while sweeping or in reset.
// Ports: CLK/RST (sync, active-high), flush_req pulse, init_done status, and the bus
// interface carrying read/write requests, read data and the SRAM macro pins.
module ct_spsram_2048x59_arb #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 59,
    parameter int                    STARVE_MAX = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush_req,
    output logic                   init_done,
    ct_spsram_2048x59_arb_if.slave bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_data_vld_q, rd_data_vld_d;
    logic                  rd_gnt, wr_gnt;

    always_comb begin
        state_d       = state_q;
        sweep_cnt_d   = sweep_cnt_q;
        starve_cnt_d  = starve_cnt_q;
        rd_gnt        = 1'b0;
        wr_gnt        = 1'b0;
        bus.sram_a    = '0;
        bus.sram_cen  = 1'b1;
        bus.sram_d    = '0;
        bus.sram_gwen = 1'b1;
        bus.sram_wen  = '1;

        // In the reset cycle everything stays idle; the flops reload on the edge.
        if (!RST) begin
            case (state_q)
                ST_SWEEP: begin
                    bus.sram_a    = sweep_cnt_q;
                    bus.sram_cen  = 1'b0;
                    bus.sram_d    = INIT_VALUE;
                    bus.sram_gwen = 1'b0;
                    bus.sram_wen  = '0;
                    // Counter wraps to 0 naturally after the last address.
                    sweep_cnt_d   = sweep_cnt_q + ADDR_WIDTH'(1);
                    if (&sweep_cnt_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.rd_req_vld && bus.wr_req_vld) begin
                        if (starve_cnt_q == STARVE_LIMIT) begin
                            wr_gnt = 1'b1;
                        end else begin
                            // Read wins, so the counter is below the limit here
                            // and the increment cannot overshoot it.
                            rd_gnt       = 1'b1;
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        rd_gnt = bus.rd_req_vld;
                        wr_gnt = bus.wr_req_vld;
                    end

                    if (wr_gnt) begin
                        starve_cnt_d  = '0;
                        bus.sram_a    = bus.wr_req_addr;
                        bus.sram_cen  = 1'b0;
                        bus.sram_d    = bus.wr_req_data;
                        bus.sram_gwen = 1'b0;
                        bus.sram_wen  = ~bus.wr_req_bmask;
                    end else if (rd_gnt) begin
                        bus.sram_a   = bus.rd_req_addr;
                        bus.sram_cen = 1'b0;
                    end

                    // This cycle's access still completes; the sweep starts next cycle.
                    if (flush_req) begin
                        state_d     = ST_SWEEP;
                        sweep_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                end
            endcase
        end

        init_done_d   = (state_d == ST_RUN);
        rd_data_vld_d = rd_gnt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_SWEEP;
            sweep_cnt_q   <= '0;
            starve_cnt_q  <= '0;
            init_done_q   <= 1'b0;
            rd_data_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_cnt_q   <= sweep_cnt_d;
            starve_cnt_q  <= starve_cnt_d;
            init_done_q   <= init_done_d;
            rd_data_vld_q <= rd_data_vld_d;
        end
    end

    assign init_done       = init_done_q;
    assign bus.rd_req_gnt  = rd_gnt;
    assign bus.wr_req_gnt  = wr_gnt;
    assign bus.rd_data_vld = rd_data_vld_q;
    // The macro registers its output, so sram_q already lines up with rd_data_vld.
    assign bus.rd_data     = bus.sram_q;

endmodule
